// File: rtl/pop_rank_streamer.sv
// Streams the first KEEP entries of a captured rank-ordered index list over valid/ready.
// Optional permutation checking is built when POP_RANK_PERMUTATION_CHECK_EN is defined.
module pop_rank_streamer #(
   parameter int POP_SIZE = 50,
   parameter int IDX_W    = 6,
   parameter int KEEP     = 50
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [POP_SIZE*IDX_W-1:0] sorted,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [IDX_W-1:0]          out_index,
   output logic [IDX_W-1:0]          out_rank,
   output logic                      out_last,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);

   // state  | meaning
   // IDLE   | waiting for start; capture on start=1
   // STREAM | presenting captured[rank], advancing on each transfer
   // DONE   | all KEEP ranks sent; waits for start=0 before rearming
   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

   localparam logic [IDX_W-1:0] LAST_RANK = IDX_W'(KEEP - 1);

   state_t                    r_state;
   state_t                    w_next;
   logic [POP_SIZE*IDX_W-1:0] r_capture;
   logic [IDX_W-1:0]          r_rank;
   logic [IDX_W-1:0]          w_sel;
   logic                      w_capture;
   logic                      w_xfer;
   logic                      w_last;

   assign w_sel  = r_capture[IDX_W*r_rank +: IDX_W];
   assign w_last = (r_rank == LAST_RANK);
   assign w_xfer = (r_state == S_STREAM) && out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_index = '0;
      out_rank  = '0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_capture = 1'b1;
               w_next    = S_STREAM;
            end
         end
         S_STREAM: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_index = w_sel;
            out_rank  = r_rank;
            out_last  = w_last;
            if (w_xfer && w_last) w_next = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            if (!start) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_capture <= '0;
         r_rank    <= '0;
      end else if (w_capture) begin
         r_capture <= sorted;
         r_rank    <= '0;
      end else if (w_xfer && !w_last) begin
         r_rank <= r_rank + 1'b1;
      end
   end

`ifdef POP_RANK_PERMUTATION_CHECK_EN
   logic [POP_SIZE-1:0] r_seen;
   logic                r_err;
   logic                w_oob;

   assign w_oob = (int'(w_sel) >= POP_SIZE);

   // Out-of-range indices flag the error but leave the bitmap untouched.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_seen <= '0;
         r_err  <= 1'b0;
      end else if (w_capture) begin
         r_seen <= '0;
         r_err  <= 1'b0;
      end else if (w_xfer) begin
         if (w_oob) begin
            r_err <= 1'b1;
         end else begin
            if (r_seen[w_sel]) r_err <= 1'b1;
            r_seen[w_sel] <= 1'b1;
         end
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pop_rank_streamer.sv
// Scoreboarded bench for pop_rank_streamer: a KEEP=50 and a KEEP=10 instance share stimulus.
`timescale 1ns/1ps
module tb_pop_rank_streamer;
   localparam int POP = 50;
   localparam int W   = 6;
   localparam int K1  = 50;
   localparam int K2  = 10;

   logic           clk = 1'b0;
   logic           rst_n, start, out_ready;
   logic [POP*W-1:0] sorted;
   logic           v1, l1, b1, d1, e1;
   logic [W-1:0]   i1, r1;
   logic           v2, l2, b2, d2, e2;
   logic [W-1:0]   i2, r2;

   always #5 clk = ~clk;

   pop_rank_streamer #(.POP_SIZE(POP), .IDX_W(W), .KEEP(K1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sorted(sorted),
      .out_valid(v1), .out_ready(out_ready), .out_index(i1), .out_rank(r1),
      .out_last(l1), .busy(b1), .done(d1), .err(e1));

   pop_rank_streamer #(.POP_SIZE(POP), .IDX_W(W), .KEEP(K2)) dut_k10 (
      .clk(clk), .rst_n(rst_n), .start(start), .sorted(sorted),
      .out_valid(v2), .out_ready(out_ready), .out_index(i2), .out_rank(r2),
      .out_last(l2), .busy(b2), .done(d2), .err(e2));

   int compared   = 0;
   int mismatched = 0;
   int xfers1     = 0;
   int xfers2     = 0;
   int arr[POP];
   logic [12:0] q1[$];
   logic [12:0] q2[$];

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Items are {last, rank, index}; stalled items must not change.
   logic [12:0] hold1, hold2;
   logic        stall1 = 1'b0, stall2 = 1'b0;

   always @(negedge clk) begin
      if (stall1 && v1) check("stall_hold_k50", {19'd0, l1, r1, i1}, {19'd0, hold1});
      stall1 = v1 && !out_ready && rst_n;
      hold1  = {l1, r1, i1};
      if (v1 && out_ready) begin
         xfers1++;
         if (q1.size() == 0) check("sb_empty_k50", q1.size(), 1);
         else check("item_k50", {19'd0, l1, r1, i1}, {19'd0, q1.pop_front()});
      end
   end

   always @(negedge clk) begin
      if (stall2 && v2) check("stall_hold_k10", {19'd0, l2, r2, i2}, {19'd0, hold2});
      stall2 = v2 && !out_ready && rst_n;
      hold2  = {l2, r2, i2};
      if (v2 && out_ready) begin
         xfers2++;
         if (q2.size() == 0) check("sb_empty_k10", q2.size(), 1);
         else check("item_k10", {19'd0, l2, r2, i2}, {19'd0, q2.pop_front()});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load();
      logic [POP*W-1:0] v;
      v = '0;
      for (int r = 0; r < POP; r++) begin
         v[W*r +: W] = W'(arr[r]);
         if (r < K1) q1.push_back({(r == K1-1), W'(r), W'(arr[r])});
         if (r < K2) q2.push_back({(r == K2-1), W'(r), W'(arr[r])});
      end
      sorted = v;
   endtask

   task automatic wait_done1(int budget);
      int n;
      n = 0;
      while (!d1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("done_timeout", d1, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int x0;
      int n;
      rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; sorted = '0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_valid", v1, 0);
      check("rst_busy", b1, 0);
      check("rst_done", d1, 0);
      check("rst_err", e1, 0);
      check("rst_last", l1, 0);
      check("rst_index", i1, 0);
      check("rst_rank", r1, 0);
      check("rst_k10_valid", v2, 0);
      step();
      rst_n = 1'b1;

      // Basic stream, reverse order, full throughput
      for (int r = 0; r < POP; r++) arr[r] = 49 - r;
      load();
      out_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      check("pre_capture_valid", v1, 0);
      step();
      start = 1'b0;
      for (int c = 0; c < K1; c++) begin
         @(negedge clk);
         check("basic_valid", v1, 1);
         check("basic_busy", b1, 1);
         check("basic_rank", r1, c);
         if (c == K2) check("k10_done", d2, 1);
      end
      @(negedge clk);
      check("basic_valid_drop", v1, 0);
      check("basic_done", d1, 1);
      check("basic_busy_drop", b1, 0);
      check("basic_sb_k50", q1.size(), 0);
      check("basic_sb_k10", q2.size(), 0);
      step();
      @(negedge clk);
      check("basic_back_idle", d1, 0);

      // Backpressure with ready pattern 1,0,0,1
      for (int r = 0; r < POP; r++) arr[r] = (r * 7) % 50;
      load();
      start = 1'b1;
      step();
      start = 1'b0;
      x0 = xfers1;
      n = 0;
      while (!d1 && n < 400) begin
         out_ready = (n % 4 == 0) || (n % 4 == 3);
         step();
         n++;
      end
      check("bp_done", d1, 1);
      check("bp_xfers", xfers1 - x0, K1);
      check("bp_sb_k50", q1.size(), 0);
      check("bp_sb_k10", q2.size(), 0);
      out_ready = 1'b1;
      step();

      // Partial keep with start held high through DONE
      for (int r = 0; r < POP; r++) arr[r] = r;
      load();
      start = 1'b1;
      step();
      for (int c = 0; c < K2; c++) begin
         @(negedge clk);
         check("k10_valid", v2, 1);
         check("k10_rank", r2, c);
         check("k10_last", l2, (c == K2-1));
      end
      repeat (4) begin
         @(negedge clk);
         check("k10_hold_done", d2, 1);
         check("k10_hold_novalid", v2, 0);
      end
      step();
      start = 1'b0;
      step();
      @(negedge clk);
      check("k10_idle_done", d2, 0);
      check("k10_idle_busy", b2, 0);
      check("k50_still_busy", b1, 1);
      wait_done1(200);
      check("pk_sb_k50", q1.size(), 0);
      step();

      // Input isolation: sorted changes after capture
      for (int r = 0; r < POP; r++) arr[r] = (r * 3 + 1) % 50;
      load();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      sorted = '1;
      wait_done1(200);
      check("iso_sb_k50", q1.size(), 0);
      check("iso_sb_k10", q2.size(), 0);
      step();

      // Reset mid-stream at rank 20
      for (int r = 0; r < POP; r++) arr[r] = (r * 11 + 5) % 50;
      load();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (20) step();
      @(negedge clk);
      check("mid_rank", r1, 20);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", v1, 0);
      check("mid_rst_last", l1, 0);
      check("mid_rst_busy", b1, 0);
      check("mid_rst_done", d1, 0);
      check("mid_rst_index", i1, 0);
      check("mid_rst_rank", r1, 0);
      q1.delete();
      q2.delete();
      for (int r = 0; r < POP; r++) arr[r] = (r * 13 + 2) % 50;
      load();
      start = 1'b1;
      step();
      start = 1'b0;
      @(negedge clk);
      check("restart_rank", r1, 0);
      check("restart_index", i1, arr[0]);
      wait_done1(200);
      check("restart_sb_k50", q1.size(), 0);
      step();

`ifdef POP_RANK_PERMUTATION_CHECK_EN
      for (int r = 0; r < POP; r++) arr[r] = r;
      arr[3] = 12; arr[7] = 12; arr[12] = 3;
      load();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check("dup_err_low", e1, 0);
      end
      @(negedge clk);
      check("dup_err_set", e1, 1);
      wait_done1(200);
      check("dup_err_sticky", e1, 1);
      step();
      for (int r = 0; r < POP; r++) arr[r] = r;
      arr[0] = 63;
      load();
      start = 1'b1;
      step();
      start = 1'b0;
      @(negedge clk);
      check("oob_err_cleared", e1, 0);
      @(negedge clk);
      check("oob_err_set", e1, 1);
      wait_done1(200);
      step();
`else
      check("err_tied_k50", e1, 0);
      check("err_tied_k10", e2, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
